// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/bubble control with fetch-redirect tracking
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_is_load,
  input  logic        br_taken,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        bubble_id_ex,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {RUN, DWAIT, IWAIT, REDIRECT} state_t;
  state_t state, state_n;
  logic redirect_pending, pending_n;
  logic load_use, dbusy, ibusy, resuming;
  assign load_use = id_ex_is_load & (id_ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == id_ex_rd)) | (id_uses_rs2 & (id_rs2 == id_ex_rd)));
  assign dbusy = dmem_req & ~dmem_resp;
  assign ibusy = imem_read & ~imem_resp;
  // A redirect parked behind a data miss resumes once the data access completes
  assign resuming = redirect_pending & ((state == REDIRECT) | (state == DWAIT));
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    bubble_id_ex = 1'b0;
    state_n      = RUN;
    pending_n    = redirect_pending;
    if (dbusy) begin
      {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
      state_n = DWAIT;
    end else if (resuming) begin
      if (ibusy) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        state_n     = REDIRECT;
      end else begin
        flush_if_id = 1'b1;
        pending_n   = 1'b0;
      end
    end else if (br_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      pending_n   = ibusy;
      state_n     = ibusy ? REDIRECT : RUN;
    end else if (load_use | ibusy) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      state_n      = load_use ? RUN : IWAIT;
    end
    if (!rst) begin
      {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b00000;
      {flush_if_id, flush_id_ex, bubble_id_ex} = 3'b000;
      state_n   = RUN;
      pending_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
      stall_count      <= 32'd0;
    end else begin
      state            <= state_n;
      redirect_pending <= pending_n;
      stall_count      <= stall_count + {31'd0, stall_pc};
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector bench for hazard_unit
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, id_ex_is_load = 0;
  logic br_taken = 0, imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, bubble_id_ex;
  logic [31:0] stall_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_unit dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_is_load(id_ex_is_load), .br_taken(br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .bubble_id_ex(bubble_id_ex),
    .stall_count(stall_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // exp order: {stall_pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex, bubble_id_ex}
  task automatic vec(input string tag, input logic b, ir, irs, dr, drs, input logic [7:0] exp);
    br_taken = b; imem_read = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    #1;
    check(tag, {24'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                flush_if_id, flush_id_ex, bubble_id_ex}, {24'd0, exp});
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    vec("rst_dmiss", 0, 0, 0, 1, 0, 8'h00);
    vec("rst_brib", 1, 1, 0, 0, 0, 8'h00);
    check("rst_cnt", stall_count, 0);
    rst = 1'b1;
    vec("idle", 0, 0, 0, 0, 0, 8'h00);
    id_ex_is_load = 1; id_ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    vec("lu_rs1", 0, 0, 0, 0, 0, 8'b11000001);
    id_ex_is_load = 0;
    vec("lu_done", 0, 0, 0, 0, 0, 8'h00);
    check("lu_cnt", stall_count, 1);
    id_ex_is_load = 1; id_uses_rs1 = 0;
    vec("lu_nouse", 0, 0, 0, 0, 0, 8'h00);
    id_rs2 = 5; id_uses_rs2 = 1;
    vec("lu_rs2", 0, 0, 0, 0, 0, 8'b11000001);
    id_ex_rd = 0; id_rs2 = 0; id_rs1 = 0; id_uses_rs1 = 1;
    vec("lu_x0", 0, 0, 0, 0, 0, 8'h00);
    check("x0_cnt", stall_count, 2);
    id_ex_rd = 5; id_rs1 = 5; id_uses_rs2 = 0;
    vec("br_over_lu", 1, 0, 0, 0, 0, 8'b00000110);
    vec("dmiss_over_br", 1, 0, 0, 1, 0, 8'b11111000);
    id_ex_is_load = 0;
    vec("dmiss_1", 0, 0, 0, 1, 0, 8'b11111000);
    vec("dmiss_2", 0, 0, 0, 1, 0, 8'b11111000);
    vec("dmiss_resp", 0, 0, 0, 1, 1, 8'h00);
    check("dmiss_cnt", stall_count, 5);
    vec("redir_br", 1, 1, 0, 0, 0, 8'b00000110);
    vec("redir_w1", 0, 1, 0, 0, 0, 8'b11000000);
    vec("redir_w2", 0, 1, 0, 0, 0, 8'b11000000);
    vec("redir_resp", 0, 1, 1, 0, 0, 8'b00000100);
    vec("redir_run", 0, 1, 1, 0, 0, 8'h00);
    check("redir_cnt", stall_count, 7);
    vec("imiss", 0, 1, 0, 0, 0, 8'b11000001);
    vec("imiss_resp", 0, 1, 1, 0, 0, 8'h00);
    vec("ovl_br", 1, 1, 0, 0, 0, 8'b00000110);
    vec("ovl_redir", 0, 1, 0, 0, 0, 8'b11000000);
    vec("ovl_d1", 0, 1, 0, 1, 0, 8'b11111000);
    vec("ovl_d2", 0, 1, 0, 1, 0, 8'b11111000);
    vec("ovl_dresp", 0, 1, 0, 1, 1, 8'b11000000);
    vec("ovl_iresp", 0, 1, 1, 0, 0, 8'b00000100);
    vec("ovl_run", 0, 0, 0, 0, 0, 8'h00);
    check("ovl_cnt", stall_count, 12);
    vec("sim_br", 1, 1, 0, 0, 0, 8'b00000110);
    vec("sim_d", 0, 1, 0, 1, 0, 8'b11111000);
    vec("sim_both", 0, 1, 1, 1, 1, 8'b00000100);
    vec("sim_run", 0, 1, 1, 0, 0, 8'h00);
    check("sim_cnt", stall_count, 13);
    vec("rr_br", 1, 1, 0, 0, 0, 8'b00000110);
    rst = 0;
    vec("rr_in_rst", 0, 1, 1, 0, 0, 8'h00);
    rst = 1;
    vec("rr_after", 0, 1, 1, 0, 0, 8'h00);
    check("rr_cnt", stall_count, 0);
    vec("rd_miss", 0, 0, 0, 1, 0, 8'b11111000);
    rst = 0;
    vec("rd_in_rst", 0, 0, 0, 1, 0, 8'h00);
    rst = 1;
    vec("rd_after", 0, 0, 0, 0, 0, 8'h00);
    check("rd_cnt", stall_count, 0);
    force dut.stall_count = 32'hFFFF_FFFE;
    #1 release dut.stall_count;
    vec("wrap_1", 0, 0, 0, 1, 0, 8'b11111000);
    check("wrap_max", stall_count, 32'hFFFF_FFFF);
    vec("wrap_2", 0, 0, 0, 1, 0, 8'b11111000);
    check("wrap_zero", stall_count, 32'd0);
    vec("wrap_3", 0, 0, 0, 1, 0, 8'b11111000);
    check("wrap_one", stall_count, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-low (state cleared on a clk edge while rst==0).
REQ-003 SHALL have ports id_rs1 and id_rs2, input, rv32i_reg (5), source registers of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1, each high when the ID instruction reads that source.
REQ-005 SHALL have ports id_ex_rd (input, rv32i_reg) and id_ex_is_load (input, 1): destination and load flag of the instruction in EX.
REQ-006 SHALL have port br_taken, input, 1, EX resolves a taken branch or jump this cycle.
REQ-007 SHALL have ports imem_read (input, 1) and imem_resp (input, 1): fetch request outstanding, and fetch data valid.
REQ-008 SHALL have ports dmem_req (input, 1, MEM stage load/store active) and dmem_resp (input, 1, data access done).
REQ-009 SHALL have output ports stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and stall_mem_wb, 1 bit each, hold the named register.
REQ-010 SHALL have output ports flush_if_id, flush_id_ex and bubble_id_ex, 1 bit each: squash to NOP, or insert a NOP while ID is held.
REQ-011 SHALL have output port stall_count, 32 bits, count of cycles with stall_pc==1.

Function
REQ-012 SHALL decode internally: load_use = id_ex_is_load & (id_ex_rd!=0) & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
REQ-013 SHALL decode internally: dbusy = dmem_req & ~dmem_resp; ibusy = imem_read & ~imem_resp.
REQ-014 SHALL implement FSM states RUN, DWAIT, IWAIT and REDIRECT; all outputs combinational from state plus current inputs, so stalls apply the same cycle.
REQ-015 Priority SHALL be, highest first: dbusy, br_taken, load_use, ibusy.
REQ-016 dbusy SHALL raise every stall_* output and no flush or bubble output; next state DWAIT; DWAIT holds while dbusy and returns to RUN on the dmem_resp cycle.
REQ-017 br_taken without dbusy SHALL raise flush_if_id and flush_id_ex with no stall outputs; a load_use in the same cycle SHALL be ignored.
REQ-018 br_taken with ibusy SHALL, in addition, set redirect_pending and move to REDIRECT.
REQ-019 REDIRECT SHALL raise stall_pc and stall_if_id while ibusy; on the imem_resp cycle it SHALL raise flush_if_id, clear redirect_pending and return to RUN, so the stale fetch never enters ID.
REQ-020 load_use without dbusy or br_taken SHALL raise stall_pc, stall_if_id and bubble_id_ex for exactly one cycle; EX/MEM onward SHALL advance.
REQ-021 A repeated load_use on the cycle after a bubble SHALL be impossible by construction, since EX then holds a NOP; no extra state is required for it.
REQ-022 ibusy alone SHALL raise stall_pc, stall_if_id and bubble_id_ex (EX is fed NOPs) and move to IWAIT; IWAIT returns to RUN on imem_resp.
REQ-023 dbusy arising while in IWAIT or REDIRECT SHALL take precedence; redirect_pending SHALL survive, and the FSM SHALL resume REDIRECT after dmem_resp if the fetch is still busy.
REQ-024 Simultaneous imem_resp and dmem_resp SHALL return the FSM to RUN in one cycle, with REDIRECT's flush_if_id honored if pending.
REQ-025 stall_count SHALL increment by 1 each cycle stall_pc==1, wrap from 0xFFFFFFFF to 0, and never saturate.
REQ-026 Outputs SHALL be free of X for any known input; the default case SHALL return the FSM to RUN.

Reset
REQ-027 While rst==0 at a clk edge, state SHALL become RUN, redirect_pending 0 and stall_count 0.
REQ-028 During reset cycles all stall, flush and bubble outputs SHALL be 0.
REQ-029 Reset asserted mid-DWAIT or mid-REDIRECT SHALL abandon the pending flush with no residual effect after release.

Verification
REQ-030 Load-use: id_ex_is_load=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> stall_pc=stall_if_id=bubble_id_ex=1 that cycle only; stall_count=1.
REQ-031 x0 immunity: same as REQ-030 with rd=0 and rs1=0 -> no stall, stall_count stays 0.
REQ-032 Data miss: dmem_req=1 for 4 cycles with dmem_resp on the 4th -> all five stalls high for cycles 1-3, low on cycle 4; stall_count=3.
REQ-033 Redirect during fetch miss: br_taken=1 with imem_read=1 and no resp; imem_resp 3 cycles later -> flush_if_id+flush_id_ex on cycle 0, stall_pc for cycles 1-2, flush_if_id on cycle 3, then RUN.
REQ-034 Overlap: in REDIRECT, dmem_req=1 for 2 cycles with imem still busy -> all stalls high and no flush; after dmem_resp, REDIRECT resumes and the stale fetch is flushed on imem_resp.
REQ-035 Reset and wrap: rst=0 during DWAIT -> outputs 0 and RUN after release; stall_count forced near 0xFFFFFFFF (a long stall) -> wraps to 0.
